// File: rtl/pspin_her_gen.sv
// Handler execution request generator: queues DMA slot descriptors in order and
// turns each in-order write completion into one registered HER for PsPIN.
module pspin_her_gen #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 20,
  parameter int TAG_WIDTH   = 32,
  parameter int MSGID_WIDTH = 10,
  parameter int DEPTH       = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ADDR_WIDTH-1:0]      alloc_addr_i,
  input  logic [LEN_WIDTH-1:0]       alloc_len_i,
  input  logic [TAG_WIDTH-1:0]       alloc_tag_i,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic [TAG_WIDTH-1:0]       done_tag_i,
  input  logic                       done_valid_i,
  output logic                       done_ready_o,
  output logic [ADDR_WIDTH-1:0]      her_addr_o,
  output logic [LEN_WIDTH-1:0]       her_size_o,
  output logic [MSGID_WIDTH-1:0]     her_msgid_o,
  output logic                       her_eom_o,
  output logic                       her_valid_o,
  input  logic                       her_ready_i,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic [31:0]                tag_mismatch_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [TAG_WIDTH-1:0]  tag;
  } desc_t;

  desc_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic                   her_valid_q, her_valid_d;
  logic [ADDR_WIDTH-1:0]  her_addr_q, her_addr_d;
  logic [LEN_WIDTH-1:0]   her_size_q, her_size_d;
  logic [MSGID_WIDTH-1:0] her_msgid_q, her_msgid_d;
  logic                   her_eom_q, her_eom_d;
  logic [31:0]            mismatch_q, mismatch_d;

  desc_t head;
  logic  push, pop;

  // Ready depends only on registered occupancy, so a pop never frees room for a same-cycle push.
  assign alloc_ready_o = (count_q < CNT_W'(DEPTH));
  assign done_ready_o  = (count_q != '0) && (!her_valid_q || her_ready_i);

  assign push = alloc_valid_i && alloc_ready_o;
  assign pop  = done_valid_i && done_ready_o;
  assign head = mem_q[rd_ptr_q];

  // NOTE: descriptor storage has no reset; validity is tracked by the pointers
  // and count alone, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: alloc_addr_i, len: alloc_len_i, tag: alloc_tag_i};
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    her_valid_d = her_valid_q;
    her_addr_d  = her_addr_q;
    her_size_d  = her_size_q;
    her_msgid_d = her_msgid_q;
    her_eom_d   = her_eom_q;
    mismatch_d  = mismatch_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      her_valid_d = 1'b1;
      her_addr_d  = head.addr;
      her_size_d  = head.len;
      her_msgid_d = head.tag[MSGID_WIDTH-1:0];
      her_eom_d   = head.tag[MSGID_WIDTH];
      if ((done_tag_i != head.tag) && (mismatch_q != '1)) mismatch_d = mismatch_q + 1'b1;
    end else if (her_valid_q && her_ready_i) begin
      her_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      her_valid_q <= 1'b0;
      her_addr_q  <= '0;
      her_size_q  <= '0;
      her_msgid_q <= '0;
      her_eom_q   <= 1'b0;
      mismatch_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      her_valid_q <= her_valid_d;
      her_addr_q  <= her_addr_d;
      her_size_q  <= her_size_d;
      her_msgid_q <= her_msgid_d;
      her_eom_q   <= her_eom_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign her_valid_o    = her_valid_q;
  assign her_addr_o     = her_addr_q;
  assign her_size_o     = her_size_q;
  assign her_msgid_o    = her_msgid_q;
  assign her_eom_o      = her_eom_q;
  assign pending_o      = count_q;
  assign tag_mismatch_o = mismatch_q;

endmodule

// File: tb/tb_pspin_her_gen.sv
// Bench for pspin_her_gen: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pspin_her_gen;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] alloc_addr_i;
  logic [19:0] alloc_len_i;
  logic [31:0] alloc_tag_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [31:0] done_tag_i;
  logic        done_valid_i;
  logic        done_ready_o;
  logic [31:0] her_addr_o;
  logic [19:0] her_size_o;
  logic [9:0]  her_msgid_o;
  logic        her_eom_o;
  logic        her_valid_o;
  logic        her_ready_i;
  logic [4:0]  pending_o;
  logic [31:0] tag_mismatch_o;

  pspin_her_gen #(
    .ADDR_WIDTH(32), .LEN_WIDTH(20), .TAG_WIDTH(32), .MSGID_WIDTH(10), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .alloc_addr_i(alloc_addr_i), .alloc_len_i(alloc_len_i), .alloc_tag_i(alloc_tag_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .done_tag_i(done_tag_i), .done_valid_i(done_valid_i), .done_ready_o(done_ready_o),
    .her_addr_o(her_addr_o), .her_size_o(her_size_o), .her_msgid_o(her_msgid_o),
    .her_eom_o(her_eom_o), .her_valid_o(her_valid_o), .her_ready_i(her_ready_i),
    .pending_o(pending_o), .tag_mismatch_o(tag_mismatch_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of descriptors and the current HER.
  typedef struct {
    logic [31:0] addr;
    logic [19:0] len;
    logic [31:0] tag;
  } desc_t;

  desc_t       q[$];
  bit          m_hv    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [19:0] m_len   = '0;
  logic [31:0] m_tag   = '0;
  logic [31:0] m_mism  = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_hv = 1'b0; m_addr = '0; m_len = '0; m_tag = '0; m_mism = '0;
    end else begin
      bit can_take, can_done;
      desc_t h;
      can_take = q.size() < DEPTH;
      can_done = (q.size() > 0) && (!m_hv || her_ready_i);
      if (done_valid_i && can_done) begin
        h = q.pop_front();
        m_hv = 1'b1; m_addr = h.addr; m_len = h.len; m_tag = h.tag;
        if (done_tag_i != h.tag && m_mism != 32'hFFFF_FFFF) m_mism = m_mism + 1;
      end else if (m_hv && her_ready_i) begin
        m_hv = 1'b0;
      end
      if (alloc_valid_i && can_take) q.push_back('{alloc_addr_i, alloc_len_i, alloc_tag_i});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_pending", pending_o, q.size());
      check("cmp_alloc_ready", alloc_ready_o, q.size() < DEPTH);
      check("cmp_done_ready", done_ready_o, (q.size() > 0) && (!m_hv || her_ready_i));
      check("cmp_her_valid", her_valid_o, m_hv);
      check("cmp_mismatch", tag_mismatch_o, m_mism);
      if (m_hv) begin
        check("cmp_her_addr", her_addr_o, m_addr);
        check("cmp_her_size", her_size_o, m_len);
        check("cmp_her_msgid", her_msgid_o, m_tag[9:0]);
        check("cmp_her_eom", her_eom_o, m_tag[10]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [31:0] a, input logic [19:0] l, input logic [31:0] t);
    alloc_valid_i = v; alloc_addr_i = a; alloc_len_i = l; alloc_tag_i = t;
  endtask

  initial begin
    rstn = 1'b1;
    set_alloc(1'b0, '0, '0, '0);
    done_valid_i = 1'b0; done_tag_i = '0; her_ready_i = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    cmp_en = 1'b1;

    check("rst_pending", pending_o, 0);
    check("rst_alloc_ready", alloc_ready_o, 1);
    check("rst_done_ready", done_ready_o, 0);
    check("rst_her_valid", her_valid_o, 0);
    check("rst_her_addr", her_addr_o, 0);
    check("rst_mismatch", tag_mismatch_o, 0);

    // Single descriptor, matching completion.
    set_alloc(1'b1, 32'h1c10_0000, 20'd1536, 32'h405);
    cyc();
    set_alloc(1'b0, '0, '0, '0);
    done_valid_i = 1'b1; done_tag_i = 32'h405;
    cyc();
    done_valid_i = 1'b0;
    check("t1_valid", her_valid_o, 1);
    check("t1_addr", her_addr_o, 32'h1c10_0000);
    check("t1_size", her_size_o, 1536);
    check("t1_msgid", her_msgid_o, 10'h005);
    check("t1_eom", her_eom_o, 1);
    check("t1_mismatch", tag_mismatch_o, 0);
    her_ready_i = 1'b1;
    cyc();
    check("t1_consumed", her_valid_o, 0);

    // Fill to capacity, then a pop with a simultaneous push that must not bypass.
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1'b1, 32'h1000_0000 + i * 32'h800, 20'(64 + i), 32'(i));
      cyc();
    end
    set_alloc(1'b0, '0, '0, '0);
    check("t2_full_pending", pending_o, 16);
    check("t2_full_ready", alloc_ready_o, 0);
    set_alloc(1'b1, 32'hdead_0000, 20'd9, 32'h3ff);
    done_valid_i = 1'b1; done_tag_i = 32'd0;
    cyc();
    set_alloc(1'b0, '0, '0, '0);
    done_valid_i = 1'b0;
    check("t2_ready_back", alloc_ready_o, 1);
    check("t2_pending_15", pending_o, 15);
    check("t2_head_addr", her_addr_o, 32'h1000_0000);
    for (int i = 1; i < DEPTH; i++) begin
      done_valid_i = 1'b1; done_tag_i = 32'(i);
      cyc();
    end
    done_valid_i = 1'b0;
    check("t2_last_addr", her_addr_o, 32'h1000_7800);
    check("t2_last_msgid", her_msgid_o, 10'h00f);
    cyc();
    check("t2_drained", pending_o, 0);
    check("t2_no_mismatch", tag_mismatch_o, 0);

    // Completion offered to an empty queue is ignored.
    done_valid_i = 1'b1; done_tag_i = 32'h405;
    #1 check("t3_done_ready", done_ready_o, 0);
    cyc(); cyc();
    check("t3_no_her", her_valid_o, 0);
    check("t3_pending", pending_o, 0);
    done_valid_i = 1'b0;

    // Backpressure: first HER held, then three HERs back to back.
    her_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 32'h2000_0000 + i * 32'h100, 20'(100 + i), 32'h100 + 32'(i));
      cyc();
    end
    set_alloc(1'b0, '0, '0, '0);
    done_valid_i = 1'b1; done_tag_i = 32'h100;
    cyc();
    done_tag_i = 32'h101;
    repeat (4) cyc();
    check("t4_held_valid", her_valid_o, 1);
    check("t4_held_addr", her_addr_o, 32'h2000_0000);
    check("t4_held_size", her_size_o, 100);
    check("t4_blocked", done_ready_o, 0);
    check("t4_pending", pending_o, 2);
    her_ready_i = 1'b1;
    cyc();
    check("t4_her2_addr", her_addr_o, 32'h2000_0100);
    check("t4_her2_valid", her_valid_o, 1);
    done_tag_i = 32'h102;
    cyc();
    check("t4_her3_addr", her_addr_o, 32'h2000_0200);
    check("t4_her3_msgid", her_msgid_o, 10'h102);
    done_valid_i = 1'b0;
    cyc();
    check("t4_done", her_valid_o, 0);

    // Tag mismatch still emits the head descriptor.
    set_alloc(1'b1, 32'h3000_0000, 20'd8, 32'h10);
    cyc();
    set_alloc(1'b0, '0, '0, '0);
    done_valid_i = 1'b1; done_tag_i = 32'h11;
    cyc();
    done_valid_i = 1'b0;
    check("t5_msgid", her_msgid_o, 10'h010);
    check("t5_eom", her_eom_o, 0);
    check("t5_addr", her_addr_o, 32'h3000_0000);
    check("t5_mismatch", tag_mismatch_o, 1);

    // Simultaneous push and pop keep the count steady.
    for (int i = 0; i < 2; i++) begin
      set_alloc(1'b1, 32'h4000_0000 + 32'(i), 20'(i), 32'h200 + 32'(i));
      cyc();
    end
    for (int i = 2; i < 6; i++) begin
      set_alloc(1'b1, 32'h4000_0000 + 32'(i), 20'(i), 32'h200 + 32'(i));
      done_valid_i = 1'b1; done_tag_i = q[0].tag;
      cyc();
    end
    set_alloc(1'b0, '0, '0, '0);
    done_valid_i = 1'b0;
    check("t6_steady", pending_o, 2);
    check("t6_last_addr", her_addr_o, 32'h4000_0003);
    repeat (2) begin
      done_valid_i = 1'b1; done_tag_i = q[0].tag;
      cyc();
    end
    done_valid_i = 1'b0;
    cyc();

    // Reset mid-operation with work queued and a HER pending.
    her_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_alloc(1'b1, 32'h5000_0000 + 32'(i), 20'(i), 32'h300 + 32'(i));
      cyc();
    end
    set_alloc(1'b0, '0, '0, '0);
    done_valid_i = 1'b1; done_tag_i = 32'h300;
    cyc();
    done_valid_i = 1'b0;
    check("t7_pre_pending", pending_o, 5);
    check("t7_pre_valid", her_valid_o, 1);
    #2 rstn = 1'b0;
    #1;
    check("t7_rst_pending", pending_o, 0);
    check("t7_rst_valid", her_valid_o, 0);
    check("t7_rst_mismatch", tag_mismatch_o, 0);
    check("t7_rst_alloc_ready", alloc_ready_o, 1);
    check("t7_rst_done_ready", done_ready_o, 0);
    cyc();
    rstn = 1'b1;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pspin_her_gen.md
PSPIN_HER_GEN -- requirements
Module: pspin_her_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, slot address width.
REQ-002 SHALL have parameter LEN_WIDTH, default 20, slot length width.
REQ-003 SHALL have parameter TAG_WIDTH, default 32, packet tag width; SHALL be at least MSGID_WIDTH+1.
REQ-004 SHALL have parameter MSGID_WIDTH, default 10, message ID width.
REQ-005 SHALL have parameter DEPTH, default 16, pending-descriptor capacity; SHALL be a power of two, at least 2.
REQ-006 SHALL have port clk, input, 1, the single clock for all logic.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports alloc_addr_i, alloc_len_i, alloc_tag_i as inputs of ADDR_WIDTH, LEN_WIDTH and TAG_WIDTH: the slot descriptor issued to the DMA by the packet allocator.
REQ-009 SHALL have ports alloc_valid_i, input, 1, and alloc_ready_o, output, 1: the descriptor handshake.
REQ-010 SHALL have ports done_tag_i, input, TAG_WIDTH; done_valid_i, input, 1; and done_ready_o, output, 1: in-order DMA write completion.
REQ-011 SHALL have HER outputs her_addr_o (ADDR_WIDTH), her_size_o (LEN_WIDTH), her_msgid_o (MSGID_WIDTH), her_eom_o (1) and her_valid_o (1), plus input her_ready_i (1): the handler execution request to PsPIN.
REQ-012 SHALL have port pending_o, output, $clog2(DEPTH)+1, count of queued descriptors.
REQ-013 SHALL have port tag_mismatch_o, output, 32, count of completions whose tag differed from the head descriptor's tag.

Function
REQ-014 SHALL store accepted descriptors {addr, len, tag} in an in-order FIFO of DEPTH entries.
REQ-015 SHALL drive alloc_ready_o = (pending_o < DEPTH); when full, a pop in the same cycle SHALL NOT bypass to a push.
REQ-016 SHALL drive done_ready_o = (pending_o > 0) && (!her_valid_o || her_ready_i).
REQ-017 SHALL respond to done_ready_o low, including when the FIFO is empty, by not consuming the completion, with no state change.
REQ-018 SHALL, on a done handshake, pop the head descriptor and load the HER register on the next clock edge, asserting her_valid_o 1 cycle after the handshake.
REQ-019 SHALL load the HER register as: her_addr_o = head addr; her_size_o = head len; her_msgid_o = head tag[MSGID_WIDTH-1:0]; her_eom_o = head tag[MSGID_WIDTH].
REQ-020 SHALL, if done_tag_i != head tag on a handshake, still emit the HER from the head descriptor and increment tag_mismatch_o, saturating at 0xFFFFFFFF.
REQ-021 SHALL hold all HER outputs stable while her_valid_o && !her_ready_i.
REQ-022 SHALL clear her_valid_o after a her handshake unless a new completion is accepted in that same cycle, in which case it SHALL stay high with the new contents (back-to-back at full rate).
REQ-023 SHALL leave pending_o unchanged on a simultaneous alloc push and done pop; the count SHALL never underflow or overflow.
REQ-024 SHALL make pending_o and all HER outputs registered.

Reset
REQ-025 SHALL, while rstn is low, asynchronously clear: FIFO pointers, pending_o = 0, her_valid_o = 0, all her_* data = 0, tag_mismatch_o = 0.
REQ-026 SHALL, after reset, hold alloc_ready_o = 1 and done_ready_o = 0; reset mid-operation SHALL discard all queued descriptors and any pending HER.

Verification
REQ-027 SHALL cover: push addr 0x1c100000, len 1536, tag 0x405; then done tag 0x405 -> 1 cycle later HER addr 0x1c100000, size 1536, msgid 0x005, eom 1; tag_mismatch_o = 0.
REQ-028 SHALL cover: push 16 descriptors with no completions -> pending_o = 16, alloc_ready_o = 0; one completion -> alloc_ready_o = 1 the next cycle.
REQ-029 SHALL cover: done_valid_i high with an empty FIFO -> done_ready_o = 0, no HER, pending_o = 0.
REQ-030 SHALL cover: her_ready_i held low with 3 completions offered -> first HER stable, done_ready_o = 0; her_ready_i high -> 3 HERs on consecutive cycles, in order.
REQ-031 SHALL cover: head tag 0x10, done tag 0x11 -> HER msgid 0x010, tag_mismatch_o = 1.
REQ-032 SHALL cover: rstn pulsed low with pending_o = 5 and her_valid_o = 1 -> immediately pending_o = 0, her_valid_o = 0, tag_mismatch_o = 0.
